// File: rtl/fact_pkg.sv
// Shared constants for the factorial accelerator: register offsets,
// FSM state encoding, STATUS bit positions and the default operand limit.
package fact_pkg;

  // Register offsets, decoded from addr[3:2]
  localparam logic [1:0] OFS_N      = 2'd0;
  localparam logic [1:0] OFS_GO     = 2'd1;
  localparam logic [1:0] OFS_STATUS = 2'd2;
  localparam logic [1:0] OFS_RESULT = 2'd3;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // STATUS register bit positions
  localparam int DONE_BIT = 0;
  localparam int ERR_BIT  = 1;
  localparam int BUSY_BIT = 2;

  // Largest N whose factorial fits in 32 bits
  localparam int MAX_N_DEFAULT = 12;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: FSM, operand down-counter and one
// DATA_W x N_W multiply per clock.
//
// Command protocol: start and clear are single-cycle pulses sampled on the
// rising clock edge; both are accepted only in IDLE or DONE and are
// dropped without effect while busy. done/err/result hold until the next
// accepted command.
module fact_core
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = MAX_N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clear,
  input  logic [N_W-1:0]    n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        state
);

  localparam logic [N_W-1:0] MAX_N_V = N_W'(MAX_N);

  logic [N_W-1:0] cnt;

  assign busy = (state == ST_BUSY);

  // The counter is loaded with max(N,1) and the loop multiplies down to a
  // factor of 1, finishing once it reaches 0. This places done at edge
  // max(N,1)+1 after the GO edge; the extra multiply by 1 is harmless.
  // Command handling, iteration and completion of the factorial loop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        ST_BUSY: begin
          if (cnt == '0) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            result <= result * DATA_W'(cnt);
            cnt    <= cnt - N_W'(1);
          end
        end
        default: begin
          if (start) begin
            if (n > MAX_N_V) begin
              state  <= ST_DONE;
              err    <= 1'b1;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state  <= ST_BUSY;
              err    <= 1'b0;
              done   <= 1'b0;
              cnt    <= (n == '0) ? N_W'(1) : n;
              result <= DATA_W'(1);
            end
          end else if (clear) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/fact_device.sv
// Memory-mapped factorial accelerator: address decode, N register and the
// combinational read mux around fact_core. irq mirrors the done flag.
module fact_device
  import fact_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N_W    = 4,
  parameter int MAX_N  = MAX_N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  logic [1:0]        sel;
  logic [N_W-1:0]    n_reg;
  logic              start;
  logic              clear;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] status;
  logic [1:0]        dbg_state_unused;
  logic              addr_unused;

  // Only addr[3:2] selects a register; the rest is decoded upstream
  assign sel         = addr[3:2];
  assign addr_unused = ^{addr[31:4], addr[1:0], wdata[DATA_W-1:N_W]};

  assign start = we && (sel == OFS_GO) && wdata[0];
  assign clear = we && (sel == OFS_GO) && !wdata[0];
  assign irq   = done;

  // N register; writable at any time, the core latches its own copy at GO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_reg <= '0;
    end else if (we && (sel == OFS_N)) begin
      n_reg <= wdata[N_W-1:0];
    end
  end

  fact_core #(
    .DATA_W (DATA_W),
    .N_W    (N_W),
    .MAX_N  (MAX_N)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .clear  (clear),
    .n      (n_reg),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .state  (dbg_state_unused)
  );

  // STATUS word assembly
  always_comb begin
    status           = '0;
    status[DONE_BIT] = done;
    status[ERR_BIT]  = err;
    status[BUSY_BIT] = busy;
  end

  // Side-effect-free combinational read mux
  always_comb begin
    rdata = '0;
    case (sel)
      OFS_N:      rdata = DATA_W'(n_reg);
      OFS_GO:     rdata = DATA_W'(busy);
      OFS_STATUS: rdata = status;
      default:    rdata = result;
    endcase
  end

endmodule
